// File: rtl/alu_ctrl_mem_stage.sv
// alu_ctrl_mem_stage
// ALU-control decoder plus MEM stage of the 64-bit LEGv8-style pipeline.
// Decodes ALUOp/opcode into a 4-bit ALU operation, resolves branches,
// accesses a 32 x 64-bit data memory and registers the MEM/WB result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   alu_op, opcode        decoder inputs (ALUOp, instr[31:21])
//   alu_ctrl, alu_ctrl_err  combinational decode result / undecodable flag
//   instr                 MEM-stage instruction, [4:0] = destination reg
//   branch_target         branch address, passed through combinationally
//   alu_result            ALU result and data-memory byte address
//   store_data            data written on stores
//   zero                  ALU zero flag
//   branch, branch_zero, branch_nonzero  B / CBZ / CBNZ controls
//   mem_read, mem_write, mem_to_reg, reg_write  memory / write-back controls
//   branch_target_out, pc_src  combinational branch outputs
//   reg_write_out, wb_data, wb_reg  registered MEM/WB outputs
module alu_ctrl_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  alu_op,
   input  logic [10:0] opcode,
   output logic [3:0]  alu_ctrl,
   output logic        alu_ctrl_err,
   input  logic [31:0] instr,
   input  logic [63:0] branch_target,
   input  logic [63:0] alu_result,
   input  logic [63:0] store_data,
   input  logic        zero,
   input  logic        branch,
   input  logic        branch_zero,
   input  logic        branch_nonzero,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   output logic [63:0] branch_target_out,
   output logic        pc_src,
   output logic        reg_write_out,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_reg
);

   localparam int unsigned XLEN      = 64;
   localparam int unsigned MEM_WORDS = 32;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned REG_W     = 5;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   logic [XLEN-1:0]   r_mem [MEM_WORDS];
   logic [ADDR_W-1:0] w_addr;
   logic [XLEN-1:0]   w_mem_rdata;
   logic [XLEN-1:0]   w_wb_data;
   logic              w_unused_instr;

   // ALU control decode; unmatched codes fall back to ADD and flag an error
   always_comb begin
      alu_ctrl     = ALU_ADD;
      alu_ctrl_err = 1'b0;
      case (alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_PASSB;
         2'b10: begin
            case (opcode)
               11'b10001011000: alu_ctrl = ALU_ADD;
               11'b11001011000: alu_ctrl = ALU_SUB;
               11'b10001010000: alu_ctrl = ALU_AND;
               11'b10101010000: alu_ctrl = ALU_ORR;
               11'b11101010000: alu_ctrl = ALU_NOR;
               default:         alu_ctrl_err = 1'b1;
            endcase
         end
         2'b11: begin
            // I-type opcodes are 10 bits wide; opcode[0] belongs to the immediate
            case (opcode[10:1])
               10'b1001000100: alu_ctrl = ALU_ADD;
               10'b1101000100: alu_ctrl = ALU_SUB;
               10'b1001001000: alu_ctrl = ALU_AND;
               10'b1011001000: alu_ctrl = ALU_ORR;
               default:        alu_ctrl_err = 1'b1;
            endcase
         end
         default: alu_ctrl_err = 1'b1;
      endcase
   end

   // Branch resolution, held off while in reset
   assign pc_src = rst_n & (branch | (branch_zero & zero) | (branch_nonzero & ~zero));
   assign branch_target_out = branch_target;

   // Doubleword index; byte offset and bits above 7 are dropped (256-byte wrap)
   assign w_addr      = alu_result[7:3];
   assign w_mem_rdata = r_mem[w_addr];
   assign w_wb_data   = mem_to_reg ? w_mem_rdata : alu_result;

   // Only the destination field of the instruction is needed here
   assign w_unused_instr = ^instr[31:REG_W];

   // Data memory: cleared by reset, written at the clock edge, read asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (mem_write) begin
         r_mem[w_addr] <= store_data;
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_out <= 1'b0;
         wb_data       <= '0;
         wb_reg        <= '0;
      end else begin
         reg_write_out <= reg_write;
         wb_data       <= w_wb_data;
         wb_reg        <= instr[REG_W-1:0];
      end
   end

endmodule

// File: tb/tb_alu_ctrl_mem_stage.sv
// Self-checking bench for alu_ctrl_mem_stage: direct checks of the
// combinational decoder and branch logic, and a scoreboard of expected
// MEM/WB results backed by a reference model of the data memory.
module tb_alu_ctrl_mem_stage;

   typedef struct packed {
      logic        rw;
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [10:0] opcode;
   logic [3:0]  alu_ctrl;
   logic        alu_ctrl_err;
   logic [31:0] instr;
   logic [63:0] branch_target;
   logic [63:0] alu_result;
   logic [63:0] store_data;
   logic        zero;
   logic        branch;
   logic        branch_zero;
   logic        branch_nonzero;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic [63:0] branch_target_out;
   logic        pc_src;
   logic        reg_write_out;
   logic [63:0] wb_data;
   logic [4:0]  wb_reg;

   int          n_checks = 0;
   int          n_fail   = 0;
   wb_t         sb_q[$];
   logic [63:0] model_mem [32];

   alu_ctrl_mem_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .alu_op            (alu_op),
      .opcode            (opcode),
      .alu_ctrl          (alu_ctrl),
      .alu_ctrl_err      (alu_ctrl_err),
      .instr             (instr),
      .branch_target     (branch_target),
      .alu_result        (alu_result),
      .store_data        (store_data),
      .zero              (zero),
      .branch            (branch),
      .branch_zero       (branch_zero),
      .branch_nonzero    (branch_nonzero),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_to_reg        (mem_to_reg),
      .reg_write         (reg_write),
      .branch_target_out (branch_target_out),
      .pc_src            (pc_src),
      .reg_write_out     (reg_write_out),
      .wb_data           (wb_data),
      .wb_reg            (wb_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dec_chk(input logic [1:0] op, input logic [10:0] opc,
                          input logic [3:0] exp_ctrl, input logic exp_err);
      alu_op = op;
      opcode = opc;
      #1;
      check($sformatf("alu_ctrl op=%b opc=%b", op, opc), 64'(alu_ctrl), 64'(exp_ctrl));
      check($sformatf("alu_err op=%b opc=%b", op, opc), 64'(alu_ctrl_err), 64'(exp_err));
   endtask

   task automatic br_chk(input logic b, input logic bz, input logic bnz,
                         input logic z, input logic exp);
      branch = b; branch_zero = bz; branch_nonzero = bnz; zero = z;
      branch_target = {$urandom, $urandom};
      #1;
      check($sformatf("pc_src b=%b bz=%b bnz=%b z=%b", b, bz, bnz, z), 64'(pc_src), 64'(exp));
      check("branch_target_out", branch_target_out, branch_target);
      branch = 1'b0; branch_zero = 1'b0; branch_nonzero = 1'b0;
   endtask

   // Drive one MEM-stage instruction, push its expected MEM/WB contents, check after the edge
   task automatic issue(input string tag, input logic [31:0] ins, input logic [63:0] alu,
                        input logic [63:0] sd, input logic mr, input logic mw,
                        input logic m2r, input logic rw);
      wb_t exp;
      wb_t got;
      @(negedge clk);
      instr = ins; alu_result = alu; store_data = sd;
      mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write = rw;
      exp.rw   = rw;
      exp.rd   = ins[4:0];
      exp.data = m2r ? model_mem[alu[7:3]] : alu;
      sb_q.push_back(exp);
      if (mw) model_mem[alu[7:3]] = sd;
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check({tag, " wb_data"}, wb_data, got.data);
      check({tag, " wb_reg"}, 64'(wb_reg), 64'(got.rd));
      check({tag, " reg_write_out"}, 64'(reg_write_out), 64'(got.rw));
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      rst_n = 1'b0;
      alu_op = 2'b00; opcode = '0; instr = '0; branch_target = '0;
      alu_result = '0; store_data = '0; zero = 1'b0;
      branch = 1'b1; branch_zero = 1'b0; branch_nonzero = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
      #2;
      check("reset wb_data", wb_data, 64'd0);
      check("reset wb_reg", 64'(wb_reg), 64'd0);
      check("reset reg_write_out", 64'(reg_write_out), 64'd0);
      check("reset pc_src", 64'(pc_src), 64'd0);
      branch = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Decoder
      dec_chk(2'b00, 11'b11111111111, 4'b0010, 1'b0);
      dec_chk(2'b01, 11'b00000000000, 4'b0111, 1'b0);
      dec_chk(2'b10, 11'b10001011000, 4'b0010, 1'b0);
      dec_chk(2'b10, 11'b11001011000, 4'b0110, 1'b0);
      dec_chk(2'b10, 11'b10001010000, 4'b0000, 1'b0);
      dec_chk(2'b10, 11'b10101010000, 4'b0001, 1'b0);
      dec_chk(2'b10, 11'b11101010000, 4'b1100, 1'b0);
      dec_chk(2'b10, 11'b11111111111, 4'b0010, 1'b1);
      dec_chk(2'b10, 11'b10001011001, 4'b0010, 1'b1);
      dec_chk(2'b11, 11'b10010001001, 4'b0010, 1'b0);
      dec_chk(2'b11, 11'b10010001000, 4'b0010, 1'b0);
      dec_chk(2'b11, 11'b11010001001, 4'b0110, 1'b0);
      dec_chk(2'b11, 11'b10010010000, 4'b0000, 1'b0);
      dec_chk(2'b11, 11'b10110010001, 4'b0001, 1'b0);
      dec_chk(2'b11, 11'b11101010000, 4'b0010, 1'b1);

      // Branch resolution
      br_chk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      br_chk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      br_chk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      br_chk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      br_chk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      br_chk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Store / load with offset and wrap
      issue("store 0x18", 32'h0000_0003, 64'h18, 64'hDEADBEEF_01234567, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("load 0x1f", 32'h0000_0004, 64'h1F, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      issue("load 0x118", 32'h0000_0005, 64'h118, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      issue("alu wb", 32'h8B00_0009, 64'd42, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      issue("m2r no read", 32'h0000_001F, 64'h18, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Simultaneous read and write returns the old word
      issue("store 5", 32'h0000_0001, 64'h40, 64'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      issue("rd+wr", 32'h0000_0002, 64'h40, 64'd7, 1'b1, 1'b1, 1'b1, 1'b1);
      issue("load 7", 32'h0000_0003, 64'h40, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Random mix
      for (int k = 0; k < 40; k++) begin
         logic [3:0] c;
         c = 4'($urandom);
         issue($sformatf("rand%0d", k), $urandom, {$urandom, $urandom},
               {$urandom, $urandom}, c[0], c[1], c[2], c[3]);
      end

      // Mid-stream reset
      issue("pre-reset store", 32'h0000_0011, 64'h80, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b1);
      branch = 1'b1;
      rst_n  = 1'b0;
      #1;
      check("midreset wb_data", wb_data, 64'd0);
      check("midreset wb_reg", 64'(wb_reg), 64'd0);
      check("midreset reg_write_out", 64'(reg_write_out), 64'd0);
      check("midreset pc_src", 64'(pc_src), 64'd0);
      alu_result = 64'h88; store_data = 64'hFFFF; mem_write = 1'b1; reg_write = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("inreset wb_data", wb_data, 64'd0);
      check("inreset reg_write_out", 64'(reg_write_out), 64'd0);
      mem_write = 1'b0; reg_write = 1'b0;
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-reset pc_src", 64'(pc_src), 64'd1);
      branch = 1'b0;
      issue("post-reset load 0x80", 32'h0000_0006, 64'h80, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      issue("post-reset load 0x88", 32'h0000_0007, 64'h88, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      issue("post-reset load 0x18", 32'h0000_0008, 64'h18, 64'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
